instr_feeder: RTL



---
 rtl/instr_feeder_pkg.sv | 40 ++++
 rtl/instr_feeder_if.sv | 31 +++
 rtl/instr_feeder_prog_counter.sv | 44 ++++
 rtl/instr_feeder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/instr_feeder_pkg.sv
// -----------------------------------------------------------------------------
// feeder_pkg
// Shared definitions for the instruction feeder: opcode encodings, the FSM
// state encoding and the instruction word field positions.
// Ports: none (package).
// -----------------------------------------------------------------------------
package feeder_pkg;

    // Opcode encodings (bits 8:6 of the instruction word)
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Instruction word field positions
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 3;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

    // Feeder FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        ISSUE  = 3'd3,
        T0     = 3'd4,
        EXEC   = 3'd5,
        HALTED = 3'd6
    } feed_state_t;

    // Extract the opcode field from a 9-bit instruction word
    function automatic logic [2:0] get_opcode(input logic [8:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// -----------------------------------------------------------------------------
// instr_feeder_if
// Bundles the feeder's ROM, processor handshake and status signals.
// Signals: Start, Done, MemData (into feeder); MemAddr, DIN, Run, Pc, Busy,
// Halted, Error (out of feeder).
// Modports: master = the feeder itself, slave = ROM / processor / environment.
// -----------------------------------------------------------------------------
interface instr_feeder_if #(
    parameter int ADDR_W = 5
) ();
    logic              Start;
    logic              Done;
    logic [8:0]        MemData;
    logic [ADDR_W-1:0] MemAddr;
    logic [8:0]        DIN;
    logic              Run;
    logic [ADDR_W-1:0] Pc;
    logic              Busy;
    logic              Halted;
    logic              Error;

    modport master (
        input  Start, Done, MemData,
        output MemAddr, DIN, Run, Pc, Busy, Halted, Error
    );

    modport slave (
        output Start, Done, MemData,
        input  MemAddr, DIN, Run, Pc, Busy, Halted, Error
    );
endinterface

// File: rtl/instr_feeder_prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
// ADDR_W-bit program counter with synchronous clear and +1 / +2 increment,
// wrapping modulo 2^ADDR_W.
// Ports: clk, rst (sync, active-high), clr, inc1, inc2 (inc2 has priority
// over inc1, clr over both); pc_r = current value, pc_next_s = value after
// the next edge (used by the parent to register MemAddr ahead of time).
// -----------------------------------------------------------------------------
module prog_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc1,
    input  logic              inc2,
    output logic [ADDR_W-1:0] pc_r,
    output logic [ADDR_W-1:0] pc_next_s
);

    // Next PC selection; natural truncation gives the modulo wrap
    always_comb begin
        pc_next_s = pc_r;
        if (clr) begin
            pc_next_s = '0;
        end else if (inc2) begin
            pc_next_s = pc_r + ADDR_W'(2);
        end else if (inc1) begin
            pc_next_s = pc_r + ADDR_W'(1);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= '0;
        end else begin
            pc_r <= pc_next_s;
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
// Fetches 9-bit instructions from a synchronous ROM and feeds them to the
// processor over the Run/DIN/Done handshake, advancing the PC on Done.
// Ports: Clock, Reset (synchronous, active-high); bus (instr_feeder_if.master)
// carrying Start, Done, MemData in and MemAddr, DIN, Run, Pc, Busy, Halted,
// Error out. All outputs come straight from flops.
// Optional feature: define FEED_WATCHDOG_EN to halt with a sticky Error when
// EXEC lasts WD_CYCLES cycles without Done; otherwise Error is always 0.
// -----------------------------------------------------------------------------
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int WD_CYCLES = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    instr_feeder_if.master   bus
);

    if (WD_CYCLES < 1) begin : g_bad_wd_cycles
        $error("WD_CYCLES must be at least 1");
    end

    feed_state_t       state_r, state_next_s;
    logic [8:0]        instr_r, instr_next_s;
    logic [8:0]        imm_r, imm_next_s;
    logic [ADDR_W-1:0] memaddr_r, memaddr_next_s;
    logic [8:0]        din_r, din_next_s;
    logic              run_r, busy_r, halted_r, error_r;
    logic              pc_clr_s, pc_inc1_s, pc_inc2_s;
    logic [ADDR_W-1:0] pc_r, pc_next_s;
    logic              wd_trip_s;

    prog_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk       (Clock),
        .rst       (Reset),
        .clr       (pc_clr_s),
        .inc1      (pc_inc1_s),
        .inc2      (pc_inc2_s),
        .pc_r      (pc_r),
        .pc_next_s (pc_next_s)
    );

`ifdef FEED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Counts EXEC cycles of the current instruction; cleared outside EXEC
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wd_cnt_r <= '0;
        end else if (state_r == EXEC) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end

    // Trip on the last allowed EXEC cycle if Done has still not arrived
    assign wd_trip_s = (state_r == EXEC) && !bus.Done &&
                       (wd_cnt_r == WD_W'(WD_CYCLES - 1));
`else
    assign wd_trip_s = 1'b0;
`endif

    // Next-state logic, PC control and instruction/immediate capture
    always_comb begin
        state_next_s = state_r;
        pc_clr_s     = 1'b0;
        pc_inc1_s    = 1'b0;
        pc_inc2_s    = 1'b0;
        instr_next_s = instr_r;
        imm_next_s   = imm_r;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    state_next_s = FETCH;
                    pc_clr_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: state_next_s = LATCH;
            LATCH: begin
                instr_next_s = bus.MemData;
                if (get_opcode(bus.MemData) == OP_HALT) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            ISSUE: begin
                // ROM is returning the word at Pc+1: the mvi immediate
                imm_next_s   = bus.MemData;
                state_next_s = T0;
            end
            T0: state_next_s = EXEC;
            EXEC: begin
                if (bus.Done) begin
                    state_next_s = FETCH;
                    if (get_opcode(instr_r) == OP_MVI) begin
                        pc_inc2_s = 1'b1;
                    end else begin
                        pc_inc1_s = 1'b1;
                    end
                end else if (wd_trip_s) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = EXEC;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so they register in step
    always_comb begin
        memaddr_next_s = memaddr_r;
        din_next_s     = din_r;
        case (state_next_s)
            FETCH: memaddr_next_s = pc_next_s;
            LATCH: memaddr_next_s = pc_r + ADDR_W'(1);
            ISSUE: din_next_s = instr_next_s;
            T0:    din_next_s = instr_next_s;
            EXEC: begin
                if (get_opcode(instr_next_s) == OP_MVI) begin
                    din_next_s = imm_next_s;
                end else begin
                    din_next_s = instr_next_s;
                end
            end
            default: begin
                memaddr_next_s = memaddr_r;
                din_next_s     = din_r;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= IDLE;
            instr_r   <= 9'd0;
            imm_r     <= 9'd0;
            memaddr_r <= '0;
            din_r     <= 9'd0;
            run_r     <= 1'b0;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            instr_r   <= instr_next_s;
            imm_r     <= imm_next_s;
            memaddr_r <= memaddr_next_s;
            din_r     <= din_next_s;
            run_r     <= (state_next_s == ISSUE);
            busy_r    <= (state_next_s != IDLE) && (state_next_s != HALTED);
            halted_r  <= (state_next_s == HALTED);
            error_r   <= error_r | wd_trip_s;
        end
    end

    assign bus.MemAddr = memaddr_r;
    assign bus.DIN     = din_r;
    assign bus.Run     = run_r;
    assign bus.Pc      = pc_r;
    assign bus.Busy    = busy_r;
    assign bus.Halted  = halted_r;
    assign bus.Error   = error_r;

endmodule
